// File: rtl/cache_cam_ctrl.sv
// Request sequencer in front of cache_cam: issues one command at a time, ejects and retries full STOREs.
// Optional saturating event counters are enabled with CACHE_CAM_CTRL_STATS_EN.
package cache_cam_pkg;
  typedef enum logic [1:0] {CMD_NOP, CMD_STORE, CMD_VALID, CMD_DONE} cache_cam_cmd_e;
  typedef enum logic [1:0] {PAGE_FREE, PAGE_VALID, PAGE_DONE, PAGE_LOCKED} cache_page_status_e;
endpackage

module cache_cam_ctrl
  import cache_cam_pkg::*;
#(
  parameter int PAGES      = 32,
  parameter int KEY_WIDTH  = 14,
  parameter int DV_TIMEOUT = 8,
  parameter int RETRY_MAX  = 2,
  localparam int AWIDTH    = $clog2(PAGES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  cache_cam_cmd_e       req_cmd,
  input  logic [KEY_WIDTH-1:0] req_key,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_code,
  output logic [AWIDTH-1:0]    rsp_addr,
  output cache_page_status_e   rsp_status,
  output logic                 cam_en,
  output cache_cam_cmd_e       cam_cmd,
  output logic [KEY_WIDTH-1:0] cam_key,
  output logic                 cam_clr_en,
  output logic [AWIDTH-1:0]    cam_clr_page_addr,
  input  logic [AWIDTH-1:0]    cam_page_addr,
  input  cache_page_status_e   cam_page_status,
  input  logic                 cam_page_found,
  input  logic                 cam_page_grant,
  input  logic                 cam_page_dv,
  input  logic [AWIDTH-1:0]    cam_eject_addr,
  input  logic                 cam_eject_valid,
  output logic                 eject_valid,
  output logic [AWIDTH-1:0]    eject_addr
`ifdef CACHE_CAM_CTRL_STATS_EN
  ,
  output logic [31:0]          stat_hit,
  output logic [31:0]          stat_alloc,
  output logic [31:0]          stat_miss,
  output logic [31:0]          stat_fail,
  output logic [31:0]          stat_eject
`endif
);

  // state | meaning
  // IDLE  | ready for a client request
  // ISSUE | cam_en strobe with captured cmd/key
  // WAIT  | waiting for cam_page_dv or timeout
  // EJECT | cam_clr_en strobe on a DONE page, then retry
  // RESP  | holding response until rsp_ready
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_EJECT, S_RESP} state_e;

  localparam int TW = $clog2(DV_TIMEOUT + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [1:0] RSP_HIT = 2'd0, RSP_ALLOC = 2'd1, RSP_MISS = 2'd2, RSP_FAIL = 2'd3;

  state_e                 state, state_nxt;
  cache_cam_cmd_e         cmd_q, cmd_nxt, cam_cmd_nxt;
  logic [KEY_WIDTH-1:0]   key_q, key_nxt, cam_key_nxt;
  logic [RW-1:0]          retry_cnt, retry_nxt;
  logic [TW-1:0]          tmo_cnt, tmo_nxt;
  logic                   req_ready_nxt, rsp_valid_nxt, cam_en_nxt, clr_en_nxt, ev_valid_nxt;
  logic [1:0]             code_nxt, load_code;
  logic [AWIDTH-1:0]      addr_nxt, clr_addr_nxt, ev_addr_nxt;
  cache_page_status_e     status_nxt;
  logic                   rsp_load, eject_load;

  always_comb begin
    state_nxt     = state;
    req_ready_nxt = 1'b0;
    cmd_nxt       = cmd_q;
    key_nxt       = key_q;
    retry_nxt     = retry_cnt;
    tmo_nxt       = tmo_cnt;
    cam_en_nxt    = 1'b0;
    cam_cmd_nxt   = CMD_NOP;
    cam_key_nxt   = cam_key;
    clr_en_nxt    = 1'b0;
    clr_addr_nxt  = cam_clr_page_addr;
    ev_valid_nxt  = 1'b0;
    ev_addr_nxt   = eject_addr;
    rsp_valid_nxt = rsp_valid;
    code_nxt      = rsp_code;
    addr_nxt      = rsp_addr;
    status_nxt    = rsp_status;
    rsp_load      = 1'b0;
    load_code     = RSP_FAIL;
    eject_load    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready_nxt = 1'b1;
        if (req_valid && req_ready) begin
          cmd_nxt       = req_cmd;
          key_nxt       = req_key;
          retry_nxt     = '0;
          cam_en_nxt    = 1'b1;
          cam_cmd_nxt   = req_cmd;
          cam_key_nxt   = req_key;
          req_ready_nxt = 1'b0;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cam_page_dv) begin
          if (cmd_q == CMD_STORE) begin
            if (cam_page_grant) begin
              rsp_load = 1'b1; load_code = RSP_ALLOC;
            end else if (cam_page_found) begin
              rsp_load = 1'b1; load_code = RSP_HIT;
            end else if (cam_eject_valid && (retry_cnt < RW'(RETRY_MAX))) begin
              eject_load = 1'b1;
            end else begin
              rsp_load = 1'b1; load_code = RSP_FAIL;
            end
          end else begin
            rsp_load  = 1'b1;
            load_code = cam_page_found ? RSP_HIT : RSP_MISS;
          end
        end else if (tmo_cnt == TW'(DV_TIMEOUT - 1)) begin
          rsp_load = 1'b1; load_code = RSP_FAIL;
        end else begin
          tmo_nxt = tmo_cnt + TW'(1);
        end
      end
      S_EJECT: begin
        retry_nxt   = retry_cnt + RW'(1);
        cam_en_nxt  = 1'b1;
        cam_cmd_nxt = cmd_q;
        state_nxt   = S_ISSUE;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (eject_load) begin
      clr_en_nxt   = 1'b1;
      clr_addr_nxt = cam_eject_addr;
      ev_valid_nxt = 1'b1;
      ev_addr_nxt  = cam_eject_addr;
      state_nxt    = S_EJECT;
    end
    // only hits and allocations carry a real page back to the client
    if (rsp_load) begin
      state_nxt     = S_RESP;
      rsp_valid_nxt = 1'b1;
      code_nxt      = load_code;
      if (load_code == RSP_HIT || load_code == RSP_ALLOC) begin
        addr_nxt   = cam_page_addr;
        status_nxt = cam_page_status;
      end else begin
        addr_nxt   = '0;
        status_nxt = PAGE_FREE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      req_ready         <= 1'b0;
      cmd_q             <= CMD_NOP;
      key_q             <= '0;
      retry_cnt         <= '0;
      tmo_cnt           <= '0;
      cam_en            <= 1'b0;
      cam_cmd           <= CMD_NOP;
      cam_key           <= '0;
      cam_clr_en        <= 1'b0;
      cam_clr_page_addr <= '0;
      eject_valid       <= 1'b0;
      eject_addr        <= '0;
      rsp_valid         <= 1'b0;
      rsp_code          <= 2'd0;
      rsp_addr          <= '0;
      rsp_status        <= PAGE_FREE;
    end else begin
      state             <= state_nxt;
      req_ready         <= req_ready_nxt;
      cmd_q             <= cmd_nxt;
      key_q             <= key_nxt;
      retry_cnt         <= retry_nxt;
      tmo_cnt           <= tmo_nxt;
      cam_en            <= cam_en_nxt;
      cam_cmd           <= cam_cmd_nxt;
      cam_key           <= cam_key_nxt;
      cam_clr_en        <= clr_en_nxt;
      cam_clr_page_addr <= clr_addr_nxt;
      eject_valid       <= ev_valid_nxt;
      eject_addr        <= ev_addr_nxt;
      rsp_valid         <= rsp_valid_nxt;
      rsp_code          <= code_nxt;
      rsp_addr          <= addr_nxt;
      rsp_status        <= status_nxt;
    end
  end

`ifdef CACHE_CAM_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit   <= '0;
      stat_alloc <= '0;
      stat_miss  <= '0;
      stat_fail  <= '0;
      stat_eject <= '0;
    end else begin
      if (rsp_load && load_code == RSP_HIT   && stat_hit   != '1) stat_hit   <= stat_hit + 32'd1;
      if (rsp_load && load_code == RSP_ALLOC && stat_alloc != '1) stat_alloc <= stat_alloc + 32'd1;
      if (rsp_load && load_code == RSP_MISS  && stat_miss  != '1) stat_miss  <= stat_miss + 32'd1;
      if (rsp_load && load_code == RSP_FAIL  && stat_fail  != '1) stat_fail  <= stat_fail + 32'd1;
      if (eject_load && stat_eject != '1) stat_eject <= stat_eject + 32'd1;
    end
  end
`endif

endmodule
